pipe_dmem_resp: RTL and testbench

Multi-cycle data-memory responder for the pipelined ARM core's memory (M) stage. It accepts one load/store request at a time over a valid/ready handshake, holds it for a configurable access latency, and returns a single-cycle response carrying read data or a write acknowledgement. It replaces the single-cycle data memory and provides the responder end of the M-stage memory interface; `busy` feeds the hazard unit, which stalls the pipeline while an access is outstanding.

---
 rtl/pipe_mem_pkg.sv | 13 +
 rtl/pipe_ram_sp.sv | 24 ++
 rtl/pipe_dmem_resp.sv | 110 +++++++++++
 tb/tb_pipe_dmem_resp.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_mem_pkg.sv
// rtl/pipe_mem_pkg.sv - shared types and constants for the M-stage data-memory responder
package pipe_mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } mem_state_t;

   localparam int MEM_LAT_MAX = 15;
   localparam int MEM_CNT_W   = $clog2(MEM_LAT_MAX + 1);

endpackage

// File: rtl/pipe_ram_sp.sv
// rtl/pipe_ram_sp.sv - single-port synchronous word RAM with registered read data
module pipe_ram_sp #(
   parameter int DEPTH_WORDS = 64,
   parameter int AW          = $clog2(DEPTH_WORDS)
) (
   input  logic          clk,
   input  logic          we,
   input  logic          re,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH_WORDS];

   // rdata only moves on a read so the last load result stays visible
   always_ff @(posedge clk) begin
      if (we)
         mem[addr] <= wdata;
      if (re)
         rdata <= mem[addr];
   end

endmodule

// File: rtl/pipe_dmem_resp.sv
// rtl/pipe_dmem_resp.sv - multi-cycle load/store responder for the pipeline M stage
module pipe_dmem_resp
   import pipe_mem_pkg::*;
#(
   parameter int DEPTH_WORDS = 64,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        req_ready,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        busy
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam logic [MEM_CNT_W-1:0] CNT_LOAD = (LATENCY > 1) ? MEM_CNT_W'(LATENCY - 2) : '0;

   mem_state_t           state;
   logic [MEM_CNT_W-1:0] cnt;
   logic                 lat_we, lat_err, rd_zero;
   logic [AW-1:0]        lat_idx;
   logic [31:0]          lat_wdata;
   logic [31:0]          ram_rdata;

   logic                 in_idle, accept, enter_resp;
   logic                 req_err, cur_we, cur_err;
   logic [AW-1:0]        req_idx, cur_idx;
   logic [31:0]          cur_wdata;
   logic                 unused_addr;

   assign in_idle     = (state == IDLE);
   assign req_idx     = req_addr[AW+1:2];
   assign req_err     = |req_addr[1:0];
   assign unused_addr = ^req_addr[31:AW+2];
   assign accept      = req_valid & in_idle & ~reset;

   // with LATENCY=1 the RAM access happens on the accept edge, so use live request fields
   assign cur_we    = in_idle ? req_we    : lat_we;
   assign cur_err   = in_idle ? req_err   : lat_err;
   assign cur_idx   = in_idle ? req_idx   : lat_idx;
   assign cur_wdata = in_idle ? req_wdata : lat_wdata;

   assign enter_resp = ~reset & ((accept & (LATENCY == 1)) |
                                 ((state == BUSY) & (cnt == '0)));

   pipe_ram_sp #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (AW)
   ) u_ram (
      .clk   (clk),
      .we    (enter_resp & cur_we & ~cur_err),
      .re    (enter_resp & ~cur_we),
      .addr  (cur_idx),
      .wdata (cur_wdata),
      .rdata (ram_rdata)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         lat_we    <= 1'b0;
         lat_err   <= 1'b0;
         lat_idx   <= '0;
         lat_wdata <= '0;
         rd_zero   <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  lat_we    <= req_we;
                  lat_err   <= req_err;
                  lat_idx   <= req_idx;
                  lat_wdata <= req_wdata;
                  if (LATENCY == 1) begin
                     state <= RESP;
                  end else begin
                     state <= BUSY;
                     cnt   <= CNT_LOAD;
                  end
               end
            end
            BUSY: begin
               if (cnt == '0)
                  state <= RESP;
               else
                  cnt <= cnt - 1'b1;
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
         // misaligned loads report zero; stores leave the last load data alone
         if (enter_resp & ~cur_we)
            rd_zero <= cur_err;
      end
   end

   assign req_ready = in_idle;
   assign rsp_valid = (state == RESP);
   assign rsp_err   = (state == RESP) & lat_err;
   assign busy      = ~in_idle;
   assign rsp_rdata = rd_zero ? 32'h0 : ram_rdata;

endmodule

// File: tb/tb_pipe_dmem_resp.sv
// tb/tb_pipe_dmem_resp.sv - randomized and directed checks of pipe_dmem_resp at latencies 1, 2 and 4
module tb_pipe_dmem_resp;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid [3];
   logic        req_we    [3];
   logic [31:0] req_addr  [3];
   logic [31:0] req_wdata [3];
   logic        req_ready [3];
   logic        rsp_valid [3];
   logic [31:0] rsp_rdata [3];
   logic        rsp_err   [3];
   logic        busy      [3];

   logic [31:0] mdl_mem   [3][64];
   bit          mdl_known [3][64];
   logic [31:0] mdl_rd    [3];

   int nassert = 0;
   int nfail   = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      pipe_dmem_resp #(
         .DEPTH_WORDS (64),
         .LATENCY     ((g == 0) ? 1 : (g == 1) ? 2 : 4)
      ) u_dut (
         .clk       (clk),
         .reset     (reset),
         .req_valid (req_valid[g]),
         .req_we    (req_we[g]),
         .req_addr  (req_addr[g]),
         .req_wdata (req_wdata[g]),
         .req_ready (req_ready[g]),
         .rsp_valid (rsp_valid[g]),
         .rsp_rdata (rsp_rdata[g]),
         .rsp_err   (rsp_err[g]),
         .busy      (busy[g])
      );
   end

   function automatic int lat_of(input int d);
      return (d == 0) ? 1 : (d == 1) ? 2 : 4;
   endfunction

   task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
      nassert++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s dut%0d observed=%h expected=%h", tag, d, obs, exp);
      end
   endtask

   // one complete transaction, checking handshake, latency and response against the model
   task automatic xact(input int d, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
      int n;
      int idx;
      bit err;
      @(negedge clk);
      chk("ready_before_req", d, req_ready[d], 1);
      req_valid[d] = 1'b1;
      req_we[d]    = we;
      req_addr[d]  = addr;
      req_wdata[d] = wdata;
      @(posedge clk);
      #1;
      req_valid[d] = 1'b0;
      req_we[d]    = 1'($urandom);
      req_addr[d]  = $urandom;
      req_wdata[d] = $urandom;
      err = (addr % 4) != 0;
      idx = int'((addr / 4) % 64);
      if (we) begin
         if (!err) begin
            mdl_mem[d][idx]   = wdata;
            mdl_known[d][idx] = 1'b1;
         end
      end else begin
         mdl_rd[d] = err ? 32'h0 : mdl_mem[d][idx];
      end
      n = 0;
      do begin
         @(negedge clk);
         n++;
         chk("ready_low_while_busy", d, req_ready[d], 0);
         chk("busy_while_outstanding", d, busy[d], 1);
      end while (!rsp_valid[d] && n < 40);
      chk("latency", d, n, lat_of(d));
      chk("rsp_err", d, rsp_err[d], err);
      chk("rsp_rdata", d, rsp_rdata[d], mdl_rd[d]);
      @(negedge clk);
      chk("rsp_pulse_end", d, rsp_valid[d], 0);
      chk("ready_after_resp", d, req_ready[d], 1);
      chk("busy_after_resp", d, busy[d], 0);
   endtask

   initial begin
      logic [31:0] a;
      logic [31:0] v;
      bit          w;
      int          ix;

      reset = 1'b1;
      for (int d = 0; d < 3; d++) begin
         req_valid[d] = 1'b0;
         req_we[d]    = 1'b0;
         req_addr[d]  = '0;
         req_wdata[d] = '0;
         mdl_rd[d]    = '0;
      end
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      repeat (5) begin
         @(negedge clk);
         for (int d = 0; d < 3; d++) begin
            chk("reset_ready", d, req_ready[d], 1);
            chk("reset_busy", d, busy[d], 0);
            chk("reset_rsp_valid", d, rsp_valid[d], 0);
            chk("reset_rsp_rdata", d, rsp_rdata[d], 0);
         end
      end

      // directed: store/load, address wrap, misaligned store and load
      xact(1, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF);
      xact(1, 1'b0, 32'h0000_0040, 32'h0);
      chk("raw_value", 1, rsp_rdata[1], 32'hDEAD_BEEF);
      xact(1, 1'b1, 32'h0000_0104, 32'h1234_5678);
      xact(1, 1'b0, 32'h0000_0004, 32'h0);
      chk("wrap_value", 1, rsp_rdata[1], 32'h1234_5678);
      xact(1, 1'b1, 32'h0000_0042, 32'hFFFF_FFFF);
      xact(1, 1'b0, 32'h0000_0040, 32'h0);
      chk("misaligned_store_dropped", 1, rsp_rdata[1], 32'hDEAD_BEEF);
      xact(1, 1'b0, 32'h0000_0043, 32'h0);

      // held req_valid at LATENCY=1: response every other cycle, one cycle wide
      xact(0, 1'b1, 32'h0000_0010, 32'hA5A5_0F0F);
      @(negedge clk);
      req_valid[0] = 1'b1;
      req_we[0]    = 1'b0;
      req_addr[0]  = 32'h0000_0010;
      mdl_rd[0]    = 32'hA5A5_0F0F;
      for (int n = 1; n <= 12; n++) begin
         @(negedge clk);
         chk("held_rsp_valid", 0, rsp_valid[0], (n % 2) == 1);
         chk("held_req_ready", 0, req_ready[0], (n % 2) == 0);
         chk("held_rsp_rdata", 0, rsp_rdata[0], mdl_rd[0]);
      end
      req_valid[0] = 1'b0;
      repeat (2) @(negedge clk);

      // random traffic on every latency
      for (int k = 0; k < 20; k++) begin
         for (int d = 0; d < 3; d++) begin
            w = 1'($urandom);
            a = $urandom;
            if ($urandom_range(3, 0) != 0) a[1:0] = 2'b00;
            ix = int'((a / 4) % 64);
            if (!w && a[1:0] == 2'b00 && !mdl_known[d][ix]) w = 1'b1;
            xact(d, w, a, $urandom);
         end
      end

      // reset in the second BUSY cycle of a LATENCY=4 store drops it
      xact(2, 1'b1, 32'h0000_0080, 32'h0BAD_F00D);
      @(negedge clk);
      req_valid[2] = 1'b1;
      req_we[2]    = 1'b1;
      req_addr[2]  = 32'h0000_0080;
      req_wdata[2] = 32'h1111_2222;
      @(posedge clk);
      #1 req_valid[2] = 1'b0;
      @(negedge clk);
      chk("abort_busy_first", 2, busy[2], 1);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      for (int d = 0; d < 3; d++) mdl_rd[d] = '0;
      for (int n = 0; n < 6; n++) begin
         @(negedge clk);
         chk("abort_no_rsp", 2, rsp_valid[2], 0);
         chk("abort_idle_busy", 2, busy[2], 0);
         chk("abort_idle_ready", 2, req_ready[2], 1);
      end
      xact(2, 1'b0, 32'h0000_0080, 32'h0);
      chk("abort_old_value", 2, rsp_rdata[2], 32'h0BAD_F00D);

      // reset and req_valid together: nothing accepted
      @(negedge clk);
      reset        = 1'b1;
      req_valid[1] = 1'b1;
      req_we[1]    = 1'b1;
      req_addr[1]  = 32'h0000_0040;
      req_wdata[1] = 32'h5555_5555;
      @(posedge clk);
      #1;
      reset        = 1'b0;
      req_valid[1] = 1'b0;
      for (int d = 0; d < 3; d++) mdl_rd[d] = '0;
      @(negedge clk);
      chk("reset_wins_busy", 1, busy[1], 0);
      chk("reset_wins_ready", 1, req_ready[1], 1);
      xact(1, 1'b0, 32'h0000_0040, 32'h0);

      v = mdl_mem[1][16];
      chk("reset_wins_value", 1, rsp_rdata[1], v);

      $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
      $finish;
   end

endmodule
